// File: rtl/inst_rr_scheduler.sv
// -----------------------------------------------------------------------------
// inst_rr_scheduler
// Round-robin scheduler that lets N_REQ child instances share one resource.
// A grant is held until the owner releases it with done, drops its request
// (abort), or holds it for TIMEOUT cycles. After every release there is one
// GAP cycle and then an IDLE evaluation cycle. This gives the resource time
// to turn around before the next owner gets it.
//
// Ports
//   clk           : single clock, all logic on the rising edge
//   rst           : synchronous, active-high reset
//   req[N_REQ]    : level-sensitive request per instance
//   done[N_REQ]   : one-cycle release strobe per instance (only the owner's bit counts)
//   gnt[N_REQ]    : registered one-hot grant
//   gnt_valid     : high whenever a gnt bit is set
//   gnt_id[ID_W]  : index of the granted instance; holds its last value when idle
//   timeout_pulse : one-cycle strobe in the cycle after a grant is revoked by timeout
// -----------------------------------------------------------------------------
module inst_rr_scheduler #(
    parameter int N_REQ   = 10,
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 200,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  done,
    output logic [N_REQ-1:0]  gnt,
    output logic              gnt_valid,
    output logic [ID_W-1:0]   gnt_id,
    output logic              timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int              IW1     = ID_W + 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic              timeout_pulse_q, timeout_pulse_d;
    logic [ID_W-1:0]   pick_s;

    // First set request bit searching upward from p+1, wrapping at N_REQ-1.
    // p+1+i never exceeds 2*N_REQ-1, so one conditional subtract replaces a modulo.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                input logic [ID_W-1:0]  p);
        logic [ID_W-1:0] pick;
        logic            found;
        logic [IW1-1:0]  idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, p} + IW1'(i + 1);
            if (idx >= IW1'(N_REQ)) begin
                idx = idx - IW1'(N_REQ);
            end else begin
                idx = idx;
            end
            if (!found && r[idx[ID_W-1:0]]) begin
                pick  = idx[ID_W-1:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Next-state and next-output computation for the IDLE/BUSY/GAP FSM.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        cnt_d           = cnt_q;
        gnt_d           = gnt_q;
        gnt_valid_d     = gnt_valid_q;
        gnt_id_d        = gnt_id_q;
        timeout_pulse_d = 1'b0;
        pick_s          = rr_pick(req, ptr_q);

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d         = BUSY;
                    ptr_d           = pick_s;
                    cnt_d           = {CNT_W{1'b0}};
                    gnt_d           = {N_REQ{1'b0}};
                    gnt_d[pick_s]   = 1'b1;
                    gnt_valid_d     = 1'b1;
                    gnt_id_d        = pick_s;
                end else begin
                    gnt_d           = {N_REQ{1'b0}};
                    gnt_valid_d     = 1'b0;
                end
            end
            BUSY: begin
                // Release wins over timeout. An abort (request dropped) also
                // suppresses the pulse, because the owner let go on its own.
                if (done[gnt_id_q] || !req[gnt_id_q]) begin
                    state_d         = GAP;
                    gnt_d           = {N_REQ{1'b0}};
                    gnt_valid_d     = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d         = GAP;
                    gnt_d           = {N_REQ{1'b0}};
                    gnt_valid_d     = 1'b0;
                    timeout_pulse_d = 1'b1;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            GAP: begin
                state_d     = IDLE;
                gnt_d       = {N_REQ{1'b0}};
                gnt_valid_d = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = {N_REQ{1'b0}};
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State, pointer, hold counter and registered outputs; reset restarts the search at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            ptr_q           <= ID_W'(N_REQ - 1);
            cnt_q           <= {CNT_W{1'b0}};
            gnt_q           <= {N_REQ{1'b0}};
            gnt_valid_q     <= 1'b0;
            gnt_id_q        <= {ID_W{1'b0}};
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            cnt_q           <= cnt_d;
            gnt_q           <= gnt_d;
            gnt_valid_q     <= gnt_valid_d;
            gnt_id_q        <= gnt_id_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign gnt           = gnt_q;
    assign gnt_valid     = gnt_valid_q;
    assign gnt_id        = gnt_id_q;
    assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_inst_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_inst_rr_scheduler
// Self-checking bench for inst_rr_scheduler (N_REQ=10, TIMEOUT=4).
// It contains three parts:
//   - a table of directed vectors for the basic grant/release sequence,
//   - hand-written sequences for wrap, timeout, stray release, abort and reset,
//   - randomized traffic compared against a behavioural model.
// Cycle k starts just after rising edge k. Inputs are driven 1 ns after an edge.
// Outputs are sampled 1 ns after the following edge.
// -----------------------------------------------------------------------------
module tb_inst_rr_scheduler;

    localparam int N = 10;
    localparam int T = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [3:0]   gnt_id;
    logic         timeout_pulse;

    int checks;
    int errors;

    // behavioural model state: owner of the resource (-1 = none), cycles held,
    // quiet cycles still owed after a release, round-robin pointer, last granted id
    int   m_owner;
    int   m_held;
    int   m_quiet;
    int   m_ptr;
    int   m_last;
    logic m_pulse;
    logic [N-1:0] prev_gnt;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] done;
        logic [N-1:0] gnt;
        logic [3:0]   id;
        logic         valid;
        logic         pulse;
    } vec_t;

    vec_t vecs[9];

    inst_rr_scheduler #(
        .N_REQ   (N),
        .ID_W    (4),
        .TIMEOUT (T),
        .CNT_W   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .done          (done),
        .gnt           (gnt),
        .gnt_valid     (gnt_valid),
        .gnt_id        (gnt_id),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one clock edge, using the inputs seen at that edge.
    task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] d, input logic rs);
        int  idx;
        bit  found;
        m_pulse = 1'b0;
        if (rs) begin
            m_owner = -1;
            m_held  = 0;
            m_quiet = 0;
            m_ptr   = N - 1;
            m_last  = 0;
        end else if (m_owner >= 0) begin
            if (d[m_owner] || !r[m_owner]) begin
                m_owner = -1;
                m_quiet = 1;
            end else if (m_held == T) begin
                m_owner = -1;
                m_quiet = 1;
                m_pulse = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_quiet > 0) begin
            m_quiet--;
        end else if (r != '0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && r[idx]) begin
                    found   = 1'b1;
                    m_owner = idx;
                    m_ptr   = idx;
                    m_last  = idx;
                    m_held  = 1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, cross an edge, then check against the model and invariants.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] d, input logic rs);
        logic [31:0] exp_gnt;
        req  = r;
        done = d;
        rst  = rs;
        model_edge(r, d, rs);
        @(posedge clk);
        #1;
        exp_gnt = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        chk("model_gnt", 32'(gnt), exp_gnt);
        chk("model_gnt_id", 32'(gnt_id), 32'(m_last));
        chk("model_gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        chk("model_timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
        chk("inv_onehot", 32'($onehot0(gnt)), 32'd1);
        chk("inv_valid_or", 32'(gnt_valid), 32'(|gnt));
        chk("inv_idle_between", 32'((prev_gnt != '0) && (gnt != '0) && (gnt != prev_gnt)), 32'd0);
        prev_gnt = gnt;
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] d;
        logic         rs;
        int           cur;
        int           nxt;

        checks   = 0;
        errors   = 0;
        prev_gnt = '0;
        req      = '0;
        done     = '0;
        rst      = 1'b1;

        // basic sequence after reset: grant id 0, release in cycle 3, quiet cycles 4-5, grant id 2 in cycle 6
        vecs[0] = '{req:10'h005, done:10'h000, gnt:10'h001, id:4'd0, valid:1'b1, pulse:1'b0};
        vecs[1] = '{req:10'h005, done:10'h000, gnt:10'h001, id:4'd0, valid:1'b1, pulse:1'b0};
        vecs[2] = '{req:10'h005, done:10'h000, gnt:10'h001, id:4'd0, valid:1'b1, pulse:1'b0};
        vecs[3] = '{req:10'h005, done:10'h001, gnt:10'h000, id:4'd0, valid:1'b0, pulse:1'b0};
        vecs[4] = '{req:10'h005, done:10'h000, gnt:10'h000, id:4'd0, valid:1'b0, pulse:1'b0};
        vecs[5] = '{req:10'h005, done:10'h000, gnt:10'h004, id:4'd2, valid:1'b1, pulse:1'b0};
        vecs[6] = '{req:10'h005, done:10'h004, gnt:10'h000, id:4'd2, valid:1'b0, pulse:1'b0};
        vecs[7] = '{req:10'h000, done:10'h000, gnt:10'h000, id:4'd2, valid:1'b0, pulse:1'b0};
        vecs[8] = '{req:10'h000, done:10'h000, gnt:10'h000, id:4'd2, valid:1'b0, pulse:1'b0};

        // reset state
        step('0, '0, 1'b1);
        step(10'h3FF, 10'h3FF, 1'b1);
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("reset_gnt_id", 32'(gnt_id), 32'd0);
        chk("reset_timeout_pulse", 32'(timeout_pulse), 32'd0);

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].req, vecs[i].done, 1'b0);
            chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("vec%0d_id", i), 32'(gnt_id), 32'(vecs[i].id));
            chk($sformatf("vec%0d_valid", i), 32'(gnt_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_pulse", i), 32'(timeout_pulse), 32'(vecs[i].pulse));
        end

        // wrap: grant id 9, then req 0x201 must alternate 0,9,0,9
        step(10'h200, '0, 1'b0);
        chk("wrap_first_9", 32'(gnt), 32'h200);
        cur = 9;
        for (int k = 0; k < 4; k++) begin
            nxt = (cur == 9) ? 0 : 9;
            step(10'h201, 10'(32'd1 << cur), 1'b0);
            chk("wrap_gap", 32'(gnt), 32'd0);
            step(10'h201, '0, 1'b0);
            chk("wrap_idle", 32'(gnt), 32'd0);
            step(10'h201, '0, 1'b0);
            chk("wrap_next_gnt", 32'(gnt), 32'd1 << nxt);
            chk("wrap_next_id", 32'(gnt_id), 32'(nxt));
            cur = nxt;
        end
        step(10'h201, 10'(32'd1 << cur), 1'b0);
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);

        // timeout: req[5] held, no done, grant held exactly T cycles
        step(10'h020, '0, 1'b0);
        chk("to_gnt_c0", 32'(gnt), 32'h020);
        for (int k = 1; k < T; k++) begin
            step(10'h020, '0, 1'b0);
            chk("to_gnt_held", 32'(gnt), 32'h020);
            chk("to_no_pulse_yet", 32'(timeout_pulse), 32'd0);
        end
        step(10'h020, '0, 1'b0);
        chk("to_revoked", 32'(gnt), 32'd0);
        chk("to_pulse", 32'(timeout_pulse), 32'd1);
        step(10'h020, '0, 1'b0);
        chk("to_quiet", 32'(gnt), 32'd0);
        chk("to_pulse_single", 32'(timeout_pulse), 32'd0);
        step(10'h020, '0, 1'b0);
        chk("to_regrant", 32'(gnt), 32'h020);

        // stray release from id 3 is ignored; done[5] in the timeout cycle is a normal release
        step(10'h020, 10'h008, 1'b0);
        chk("stray_ignored", 32'(gnt), 32'h020);
        step(10'h020, '0, 1'b0);
        step(10'h020, '0, 1'b0);
        chk("stray_still_held", 32'(gnt), 32'h020);
        step(10'h020, 10'h020, 1'b0);
        chk("done_at_timeout_gnt", 32'(gnt), 32'd0);
        chk("done_at_timeout_nopulse", 32'(timeout_pulse), 32'd0);
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);

        // abort: req[7] dropped while granted
        step(10'h080, '0, 1'b0);
        chk("abort_grant", 32'(gnt), 32'h080);
        step(10'h080, '0, 1'b0);
        step('0, '0, 1'b0);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_nopulse", 32'(timeout_pulse), 32'd0);
        step('0, '0, 1'b0);

        // reset mid-grant, then req=0x3FF must grant id 0 straight away
        step(10'h080, '0, 1'b0);
        chk("rst_pre_grant", 32'(gnt), 32'h080);
        step(10'h3FF, '0, 1'b1);
        chk("rst_mid_gnt", 32'(gnt), 32'd0);
        chk("rst_mid_id", 32'(gnt_id), 32'd0);
        chk("rst_mid_valid", 32'(gnt_valid), 32'd0);
        chk("rst_mid_pulse", 32'(timeout_pulse), 32'd0);
        step(10'h3FF, '0, 1'b0);
        chk("rst_after_gnt", 32'(gnt), 32'h001);
        chk("rst_after_id", 32'(gnt_id), 32'd0);
        step(10'h3FF, 10'h001, 1'b0);
        step('0, '0, 1'b0);
        step('0, '0, 1'b0);

        // randomized traffic against the model
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            r  = r ^ N'($urandom & $urandom & $urandom & $urandom);
            d  = N'($urandom & $urandom & $urandom);
            if ((m_owner >= 0) && ($urandom_range(0, 5) == 0)) begin
                d[m_owner] = 1'b1;
            end
            rs = ($urandom_range(0, 199) == 0);
            step(r, d, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
